// File: rtl/mii_rx_checker.sv
// rtl/mii_rx_checker.sv - MII receive pattern checker with per-class character counters and fault FSM
module mii_rx_checker #(
    parameter int          DATA_WIDTH        = 64,
    parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
    parameter logic [7:0]  CTRL_CHAR_PATTERN = 8'h55,
    parameter int          CNT_WIDTH         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] ctrl_in,
    input  logic                    rx_dv,
    input  logic                    rx_er,
    input  logic                    clr_stats,
    output logic [CNT_WIDTH-1:0]    data_cnt,
    output logic [CNT_WIDTH-1:0]    ctrl_cnt,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic [15:0]             bad_cnt,
    output logic [15:0]             er_mismatch_cnt,
    output logic [1:0]              state,
    output logic                    fault,
    output logic [DATA_WIDTH/8-1:0] lane_bad
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int POP_W = $clog2(LANES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;
    logic [CNT_WIDTH-1:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q,  err_cnt_d;
    logic [15:0]          bad_cnt_q,  bad_cnt_d;
    logic [15:0]          er_mismatch_cnt_q, er_mismatch_cnt_d;
    logic [LANES-1:0]     lane_bad_q, lane_bad_d;
    logic [1:0]           state_q, state_d;

    logic [LANES-1:0] is_data;
    logic [LANES-1:0] is_ctrl;
    logic [LANES-1:0] is_err;
    logic [LANES-1:0] is_bad;
    logic             er_expected;
    logic             er_mismatch;
    logic             beat_faulty;
    logic             fault_o;

    function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add_cnt(input logic [CNT_WIDTH-1:0] a,
                                                         input logic [POP_W-1:0]     b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [15:0] sat_add_16(input logic [15:0]      a,
                                               input logic [POP_W-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        is_data = '0;
        is_ctrl = '0;
        is_err  = '0;
        is_bad  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!ctrl_in[i] && data_in[8*i +: 8] == DATA_CHAR_PATTERN) begin
                is_data[i] = 1'b1;
            end else if (ctrl_in[i] && data_in[8*i +: 8] == CTRL_CHAR_PATTERN) begin
                is_ctrl[i] = 1'b1;
            end else if (!ctrl_in[i] && data_in[8*i +: 8] == ~DATA_CHAR_PATTERN) begin
                is_err[i] = 1'b1;
            end else begin
                is_bad[i] = 1'b1;
            end
        end
    end

    // BAD lanes are deliberately excluded from the expected error flag.
    assign er_expected = |is_err;
    assign er_mismatch = rx_er != er_expected;
    assign beat_faulty = (|is_bad) || er_mismatch;

    always_comb begin
        data_cnt_d        = data_cnt_q;
        ctrl_cnt_d        = ctrl_cnt_q;
        err_cnt_d         = err_cnt_q;
        bad_cnt_d         = bad_cnt_q;
        er_mismatch_cnt_d = er_mismatch_cnt_q;
        lane_bad_d        = lane_bad_q;
        if (clr_stats) begin
            data_cnt_d        = '0;
            ctrl_cnt_d        = '0;
            err_cnt_d         = '0;
            bad_cnt_d         = '0;
            er_mismatch_cnt_d = '0;
            lane_bad_d        = '0;
        end else if (rx_dv) begin
            data_cnt_d        = sat_add_cnt(data_cnt_q, popcount(is_data));
            ctrl_cnt_d        = sat_add_cnt(ctrl_cnt_q, popcount(is_ctrl));
            err_cnt_d         = sat_add_cnt(err_cnt_q,  popcount(is_err));
            bad_cnt_d         = sat_add_16(bad_cnt_q,   popcount(is_bad));
            er_mismatch_cnt_d = sat_add_16(er_mismatch_cnt_q, POP_W'(er_mismatch));
            lane_bad_d        = is_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_cnt_q        <= '0;
            ctrl_cnt_q        <= '0;
            err_cnt_q         <= '0;
            bad_cnt_q         <= '0;
            er_mismatch_cnt_q <= '0;
            lane_bad_q        <= '0;
        end else begin
            data_cnt_q        <= data_cnt_d;
            ctrl_cnt_q        <= ctrl_cnt_d;
            err_cnt_q         <= err_cnt_d;
            bad_cnt_q         <= bad_cnt_d;
            er_mismatch_cnt_q <= er_mismatch_cnt_d;
            lane_bad_q        <= lane_bad_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_stats) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_dv) begin
                        state_d = beat_faulty ? ST_FAULT : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!rx_dv) begin
                        state_d = ST_IDLE;
                    end else if (beat_faulty) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fault_o = (state_q == ST_FAULT);
    end

    assign data_cnt        = data_cnt_q;
    assign ctrl_cnt        = ctrl_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign bad_cnt         = bad_cnt_q;
    assign er_mismatch_cnt = er_mismatch_cnt_q;
    assign lane_bad        = lane_bad_q;
    assign state           = state_q;
    assign fault           = fault_o;

endmodule

// File: tb/tb_mii_rx_checker.sv
// tb/tb_mii_rx_checker.sv - directed and randomized checks of mii_rx_checker against a lane-counting model
module tb_mii_rx_checker;

    localparam int         CW      = 8;
    localparam logic [7:0] DPAT    = 8'hAA;
    localparam logic [7:0] CPAT    = 8'h55;
    localparam int         CNT_MAX = 255;
    localparam int         W16_MAX = 65535;

    logic        clk;
    logic        rst_n;
    logic [63:0] data_in;
    logic [7:0]  ctrl_in;
    logic        rx_dv;
    logic        rx_er;
    logic        clr_stats;
    logic [CW-1:0] data_cnt;
    logic [CW-1:0] ctrl_cnt;
    logic [CW-1:0] err_cnt;
    logic [15:0] bad_cnt;
    logic [15:0] er_mismatch_cnt;
    logic [1:0]  state;
    logic        fault;
    logic [7:0]  lane_bad;

    int checks = 0;
    int errors = 0;

    int         m_data, m_ctrl, m_err, m_bad, m_erm, m_state;
    logic [7:0] m_lane_bad;

    mii_rx_checker #(
        .DATA_WIDTH(64), .DATA_CHAR_PATTERN(DPAT), .CTRL_CHAR_PATTERN(CPAT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .ctrl_in(ctrl_in),
        .rx_dv(rx_dv), .rx_er(rx_er), .clr_stats(clr_stats),
        .data_cnt(data_cnt), .ctrl_cnt(ctrl_cnt), .err_cnt(err_cnt),
        .bad_cnt(bad_cnt), .er_mismatch_cnt(er_mismatch_cnt),
        .state(state), .fault(fault), .lane_bad(lane_bad)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_data = 0; m_ctrl = 0; m_err = 0; m_bad = 0; m_erm = 0; m_state = 0;
        m_lane_bad = '0;
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Counts each lane's class directly from the octet/flag rules.
    task automatic model_step(input logic [63:0] d, input logic [7:0] c,
                              input logic er, input logic dv, input logic clr);
        int nd, nc, ne, nb;
        logic exp_er;
        logic [7:0] octet;
        logic [7:0] bm;
        if (clr) begin
            model_clear();
            return;
        end
        if (!dv) begin
            if (m_state == 1) m_state = 0;
            return;
        end
        nd = 0; nc = 0; ne = 0; nb = 0; exp_er = 1'b0; bm = '0;
        for (int i = 0; i < 8; i++) begin
            octet = d[8*i +: 8];
            if (!c[i] && octet == DPAT)       nd++;
            else if (c[i] && octet == CPAT)   nc++;
            else if (!c[i] && octet == ~DPAT) begin ne++; exp_er = 1'b1; end
            else begin nb++; bm[i] = 1'b1; end
        end
        m_data = sat(m_data + nd, CNT_MAX);
        m_ctrl = sat(m_ctrl + nc, CNT_MAX);
        m_err  = sat(m_err + ne, CNT_MAX);
        m_bad  = sat(m_bad + nb, W16_MAX);
        m_erm  = sat(m_erm + ((er != exp_er) ? 1 : 0), W16_MAX);
        m_lane_bad = bm;
        if (m_state != 2) m_state = (nb > 0 || er != exp_er) ? 2 : 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_cnt"}, 32'(data_cnt), 32'(m_data));
        chk({tag, ".ctrl_cnt"}, 32'(ctrl_cnt), 32'(m_ctrl));
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'(m_err));
        chk({tag, ".bad_cnt"},  32'(bad_cnt),  32'(m_bad));
        chk({tag, ".er_mm"},    32'(er_mismatch_cnt), 32'(m_erm));
        chk({tag, ".state"},    32'(state),    32'(m_state));
        chk({tag, ".fault"},    32'(fault),    32'(m_state == 2));
        chk({tag, ".lane_bad"}, 32'(lane_bad), 32'(m_lane_bad));
    endtask

    task automatic step(input string tag, input logic [63:0] d, input logic [7:0] c,
                        input logic er, input logic dv, input logic clr);
        @(negedge clk);
        data_in = d; ctrl_in = c; rx_er = er; rx_dv = dv; clr_stats = clr;
        @(posedge clk);
        #1;
        model_step(d, c, er, dv, clr);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_dv = 1'b0; clr_stats = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    logic [63:0] all_data;
    logic [63:0] d;
    logic [7:0]  c;
    logic [7:0]  oct;
    logic        er;
    logic        exp_er;
    logic        allow_bad;
    int          r;

    initial begin
        all_data = {8{DPAT}};
        rst_n = 1'b0; data_in = '0; ctrl_in = '0; rx_dv = 1'b0; rx_er = 1'b0; clr_stats = 1'b0;
        model_clear();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) step("all_data", all_data, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("all_data.total", 32'(data_cnt), 32'd64);
        chk("all_data.run", 32'(state), 32'd1);

        step("mix_clr", all_data, 8'h00, 1'b0, 1'b0, 1'b1);
        step("mix", {{4{DPAT}}, {4{CPAT}}}, 8'h0F, 1'b0, 1'b1, 1'b0);
        chk("mix.ctrl4", 32'(ctrl_cnt), 32'd4);
        chk("mix.run", 32'(state), 32'd1);
        step("mix_idle", '0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("mix.idle", 32'(state), 32'd0);

        step("bad_clr", all_data, 8'h00, 1'b0, 1'b0, 1'b1);
        d = all_data; d[23:16] = CPAT; d[47:40] = 8'h5A;
        step("bad_lane", d, 8'h04, 1'b0, 1'b1, 1'b0);
        chk("bad_lane.mask", 32'(lane_bad), 32'h20);
        chk("bad_lane.data6", 32'(data_cnt), 32'd6);
        for (int i = 0; i < 5; i++) step("bad_sticky", '0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("bad_sticky.fault", 32'(fault), 32'd1);

        do_reset();
        d = all_data; d[7:0] = ~DPAT;
        step("er_miss", d, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("er_miss.cnt", 32'(er_mismatch_cnt), 32'd1);
        do_reset();
        step("er_match", d, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("er_match.run", 32'(state), 32'd1);

        step("sat_clr", all_data, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 31; i++) step("sat_fill", all_data, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("sat.248", 32'(data_cnt), 32'd248);
        step("sat_a", all_data, 8'h00, 1'b0, 1'b1, 1'b0);
        step("sat_b", all_data, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("sat.ff", 32'(data_cnt), 32'hFF);
        step("sat_hold", all_data, 8'h00, 1'b0, 1'b1, 1'b0);
        step("clr_prio", all_data, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("clr_prio.zero", 32'(data_cnt), 32'd0);
        chk("clr_prio.idle", 32'(state), 32'd0);

        for (int i = 0; i < 4; i++) step("pre_rst", all_data, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        data_in = all_data; ctrl_in = 8'h00; rx_er = 1'b0; rx_dv = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst_n = 1'b1; rx_dv = 1'b0;
        step("post_rst_idle", all_data, 8'h00, 1'b0, 1'b0, 1'b0);
        step("post_rst_beat", all_data, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("post_rst.data8", 32'(data_cnt), 32'd8);

        for (int n = 0; n < 400; n++) begin
            allow_bad = ($urandom_range(0, 5) == 0);
            exp_er = 1'b0;
            for (int i = 0; i < 8; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 5)      begin oct = DPAT;  c[i] = 1'b0; end
                else if (r <= 7) begin oct = CPAT;  c[i] = 1'b1; end
                else if (r == 8 || !allow_bad) begin oct = ~DPAT; c[i] = 1'b0; exp_er = 1'b1; end
                else begin oct = 8'($urandom); c[i] = 1'($urandom); end
                d[8*i +: 8] = oct;
            end
            er = ($urandom_range(0, 9) == 0) ? 1'($urandom) : exp_er;
            step("rand", d, c, er,
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 24) == 0) || (m_state == 2 && $urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
